// File: rtl/vdc.sv
// rtl/vdc.sv - base-2 Van der Corput sequence generator (free-running count plus its bit reversal)
// Define VDC_REG_OUT_EN to drive out/out_re from flops instead of combinationally from the counter.
module vdc #(
    parameter int          N       = 2,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clock,
    input  logic         reset,
    output logic [N-1:0] out,
    output logic [N-1:0] out_re
);

    localparam logic [N-1:0] RST_CNT = RST_VAL[N-1:0];
    localparam logic [N-1:0] ONE     = 1;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    logic [N-1:0] cnt;
    logic [N-1:0] cnt_next;

    // Wrap from all-ones to zero falls out of the modulo-2^N add.
    assign cnt_next = cnt + ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= RST_CNT;
        end else begin
            cnt <= cnt_next;
        end
    end

`ifdef VDC_REG_OUT_EN
    logic [N-1:0] out_q;
    logic [N-1:0] out_re_q;

    // Loading from cnt_next keeps the flops in step with cnt, so port timing matches the combinational build.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q    <= RST_CNT;
            out_re_q <= bit_rev(RST_CNT);
        end else begin
            out_q    <= cnt_next;
            out_re_q <= bit_rev(cnt_next);
        end
    end

    assign out    = out_q;
    assign out_re = out_re_q;
`else
    assign out    = cnt;
    assign out_re = bit_rev(cnt);
`endif

endmodule

// File: tb/tb_vdc.sv
// tb/tb_vdc.sv - directed self-checking bench for vdc (N=2 default, N=3 coverage, N=3 non-zero reset value)
module tb_vdc;

    logic       clock;
    logic       reset;
    logic [1:0] out2;
    logic [1:0] out2_re;
    logic [2:0] out3;
    logic [2:0] out3_re;
    logic [2:0] outr;
    logic [2:0] outr_re;

    int n_cmp;
    int n_bad;

    vdc dut2 (
        .clock  (clock),
        .reset  (reset),
        .out    (out2),
        .out_re (out2_re)
    );

    vdc #(.N(3)) dut3 (
        .clock  (clock),
        .reset  (reset),
        .out    (out3),
        .out_re (out3_re)
    );

    vdc #(.N(3), .RST_VAL(6)) dutr (
        .clock  (clock),
        .reset  (reset),
        .out    (outr),
        .out_re (outr_re)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] run_out [6];
    logic [1:0] run_re  [6];
    logic [2:0] cov_re  [8];
    logic [2:0] rv_out  [3];
    logic [2:0] rv_re   [3];
    logic [7:0] seen;

    initial begin
        run_out = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        run_re  = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
        cov_re  = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
        rv_out  = '{3'b110, 3'b111, 3'b000};
        rv_re   = '{3'b011, 3'b111, 3'b000};
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;

        // Reset at first falling edge, checked before the next rising edge.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_out", out2, 2'b00);
        check("rst_re", out2_re, 2'b00);
        check("rst_rv_out", outr, 3'b110);
        check("rst_rv_re", outr_re, 3'b011);
        step();
        check("rst_hold_out", out2, 2'b00);
        check("rst_hold_re", out2_re, 2'b00);

        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_out", out2, 2'b00);
        step();
        check("run1_out", out2, 2'b01);
        check("run1_re", out2_re, 2'b10);
        step();
        check("run2_out", out2, 2'b10);
        check("run2_re", out2_re, 2'b01);

        // Mid-run asynchronous reset.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_out", out2, 2'b00);
        check("mid_re", out2_re, 2'b00);
        check("mid_rv_out", outr, 3'b110);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("wrap_out%0d", k), out2, run_out[k]);
            check($sformatf("wrap_re%0d", k), out2_re, run_re[k]);
        end

        // N=3 coverage window starting from reset.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            check($sformatf("cov_re%0d", k), out3_re, cov_re[k]);
            check($sformatf("cov_out%0d", k), out3, k);
            seen[out3_re] = 1'b1;
            if (k < 3) begin
                check($sformatf("rv_out%0d", k), outr, rv_out[k]);
                check($sformatf("rv_re%0d", k), outr_re, rv_re[k]);
            end
        end
        check("cov_all_seen", seen, 8'hff);
        step();
        check("cov_wrap_re", out3_re, 3'b000);
        check("cov_wrap_out", out3, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vdc.md
Name: vdc

Overview:
- Van der Corput (base-2) low-discrepancy sequence generator for the stochastic-computing FIR datapath.
- A free-running N-bit counter advances every clock.
- Outputs the plain count and its bit-reversed value; the bit-reversed value is the VDC sample.
- Downstream SNGs compare these values against binary operands to produce bitstreams.

Parameters:
- N, default 2: counter / output width in bits; sequence period is 2^N.
- RST_VAL, default 0: counter value loaded on reset; range 0..2^N-1.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- out  output  N  current counter value, natural binary order.
- out_re  output  N  bit-reversed counter value (VDC sample): out_re[i] = out[N-1-i] for all i.

Behaviour:
- One clock; reset is asynchronous and active-high.
- State: a single N-bit register cnt.
- Reset:
  - While reset=1: cnt = RST_VAL, immediately, without waiting for a clock edge.
  - With defaults: out=00 and out_re=00 during reset.
  - Holds for the whole time reset is high; clock edges are ignored.
- Run:
  - On each rising clock edge with reset=0: cnt <= cnt + 1 modulo 2^N.
  - Wrap from 2^N-1 to 0 is silent; no flag, no stall.
- Outputs (default build) are combinational from cnt:
  - out = cnt.
  - out_re = bit-reverse(cnt); pure wiring, no logic.
  - Outputs change only at a rising edge or on reset assertion.
- Latency: first increment occurs at the first rising edge after reset deasserts. A deassertion made at a falling edge takes effect at the next rising edge.
- N=2 sequence from reset:
  - out: 00,01,10,11,00,...
  - out_re: 00,10,01,11,00,...
- Reset mid-operation: counter returns to RST_VAL asynchronously. The sequence restarts from the beginning and no prior state is retained.
- Before the first reset, outputs are unspecified (X in simulation). No power-on value is guaranteed.
- Over any aligned window of 2^N cycles, out_re takes every value 0..2^N-1 exactly once.
- N=1 is legal: out_re == out.

Optional Feature:
- Macro: VDC_REG_OUT_EN.
- Defined:
  - out and out_re are driven from output registers loaded from the next counter value.
  - Values at the ports still match the undefined-macro build cycle-for-cycle, but are glitch-free flop outputs.
  - Output registers also reset asynchronously to RST_VAL / bit-reverse(RST_VAL).
- Undefined: outputs are combinational from cnt as described above.
- Port list and visible sequence are identical in both builds.

Test Plan:
- Reset assert: clock 10 ns period, reset=1 at first falling edge -> out=00, out_re=00 immediately, before any rising edge.
- Count run: release reset at a falling edge -> after 1st rising edge out=01/out_re=10; after 2nd rising edge out=10/out_re=01.
- Mid-run reset: at out=10, assert reset at a falling edge -> out=00/out_re=00 without a clock edge. Release -> sequence restarts at 01/10.
- Wrap-around: run 6 rising edges after reset -> out = 01,10,11,00,01,10; out_re = 10,01,11,00,10,01. No glitch at 11->00.
- Coverage: N=3, 8 cycles -> out_re = 000,100,010,110,001,101,011,111, each value once. Repeat with VDC_REG_OUT_EN defined -> identical port values every cycle.
